seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 41 ++++
 rtl/seg_encode.sv | 23 ++
 rtl/seg_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the three-digit segment scan controller:
// character codes, gfedcba segment patterns and one-hot digit enables.
package seg_pkg;

  typedef enum logic {
    ST_DARK = 1'b0,
    ST_LIT  = 1'b1
  } scan_state_e;

  localparam logic [4:0] CH_S     = 5'h10;
  localparam logic [4:0] CH_E     = 5'h11;
  localparam logic [4:0] CH_P     = 5'h12;
  localparam logic [4:0] CH_BLANK = 5'h1F;

  // Hex glyphs 0..F, entry n at index n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [6:0] SEG_S   = 7'h6D;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_P   = 7'h73;
  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_D0   = 3'b001;
  localparam logic [2:0] SEL_D1   = 3'b010;
  localparam logic [2:0] SEL_D2   = 3'b100;

  localparam logic [1:0] IDX_LAST = 2'd2;

  function automatic logic [2:0] digit_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    return SEL_D0;
      2'd1:    return SEL_D1;
      2'd2:    return SEL_D2;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/seg_encode.sv
// Combinational character-code to 7-segment (gfedcba) lookup.
module seg_encode
  import seg_pkg::*;
(
  input  logic [4:0] ch,
  output logic [6:0] seg
);

  // Letters first; remaining codes with bit 4 set are blank.
  always_comb begin
    seg = SEG_OFF;
    case (ch)
      CH_S:    seg = SEG_S;
      CH_E:    seg = SEG_E;
      CH_P:    seg = SEG_P;
      default: begin
        if (ch[4] == 1'b0) seg = SEG_HEX[ch[3:0]];
        else               seg = SEG_OFF;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Three-digit multiplexed 7-segment scan controller with shadow/active
// buffers and frame-aligned commit. Define SEG_SCAN_DP_EN to drive the dp segment.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV   = 100000,
  parameter int BLANK = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_idx,
  input  logic [4:0] wr_char,
  input  logic       wr_dp,
  input  logic       commit,
  output logic [2:0] sel,
  output logic [7:0] data
);

  localparam int CNT_MAX = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

  scan_state_e     state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [1:0]      digit_r, digit_s;
  logic            pending_r, pending_s;
  logic            wr_ready_r, ready_s;
  logic [2:0]      sel_r, sel_s;
  logic [7:0]      data_r, data_s;
  logic            frame_end_s, copy_s, wr_fire_s, commit_fire_s;
  logic [2:0][4:0] shadow_char_r, active_char_r;
  logic [4:0]      lit_char_s;
  logic [6:0]      seg_s;
  logic            lit_dp_s;

  assign wr_ready = wr_ready_r;
  assign sel      = sel_r;
  assign data     = data_r;

  // State, counter, handshake and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_DARK;
      cnt_r      <= '0;
      digit_r    <= 2'd0;
      pending_r  <= 1'b0;
      wr_ready_r <= 1'b0;
      sel_r      <= SEL_NONE;
      data_r     <= 8'h00;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      digit_r    <= digit_s;
      pending_r  <= pending_s;
      wr_ready_r <= ready_s;
      sel_r      <= sel_s;
      data_r     <= data_s;
    end
  end

  // Next-state: DARK for BLANK cycles, LIT for DIV cycles, digit advances on LIT exit.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r + CW'(1'b1);
    digit_s     = digit_r;
    frame_end_s = 1'b0;
    case (state_r)
      ST_DARK: begin
        if (cnt_r == BLANK_LAST) begin
          state_s = ST_LIT;
          cnt_s   = '0;
        end else begin
          state_s = ST_DARK;
        end
      end
      ST_LIT: begin
        if (cnt_r == DIV_LAST) begin
          state_s     = ST_DARK;
          cnt_s       = '0;
          frame_end_s = (digit_r == IDX_LAST);
          digit_s     = (digit_r == IDX_LAST) ? 2'd0 : digit_r + 2'd1;
        end else begin
          state_s = ST_LIT;
        end
      end
      default: begin
        state_s = ST_DARK;
        cnt_s   = '0;
        digit_s = 2'd0;
      end
    endcase
  end

  // Commit handshake: ready stays low through the copy edge and returns one cycle later.
  always_comb begin
    wr_fire_s     = wr_valid && wr_ready_r;
    commit_fire_s = commit && wr_ready_r;
    copy_s        = frame_end_s && pending_r;
    if (copy_s)             pending_s = 1'b0;
    else if (commit_fire_s) pending_s = 1'b1;
    else                    pending_s = pending_r;
    ready_s = !pending_s && !copy_s;
  end

  // Shadow writes (index 3 matches no entry) and frame-boundary copy to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_char_r <= {3{CH_BLANK}};
      active_char_r <= {3{CH_BLANK}};
    end else begin
      if (copy_s) active_char_r <= shadow_char_r;
      for (int i = 0; i < 3; i++) begin
        if (wr_fire_s && (wr_idx == 2'(i))) shadow_char_r[i] <= wr_char;
      end
    end
  end

`ifdef SEG_SCAN_DP_EN
  logic [2:0] shadow_dp_r, active_dp_r;

  // Decimal-point storage mirrors the character buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_dp_r <= 3'b000;
      active_dp_r <= 3'b000;
    end else begin
      if (copy_s) active_dp_r <= shadow_dp_r;
      for (int i = 0; i < 3; i++) begin
        if (wr_fire_s && (wr_idx == 2'(i))) shadow_dp_r[i] <= wr_dp;
      end
    end
  end

  // dp of the digit about to be shown.
  always_comb begin
    case (digit_s)
      2'd0:    lit_dp_s = active_dp_r[0];
      2'd1:    lit_dp_s = active_dp_r[1];
      2'd2:    lit_dp_s = active_dp_r[2];
      default: lit_dp_s = 1'b0;
    endcase
  end
`else
  logic dp_unused_s;
  assign dp_unused_s = wr_dp;
  assign lit_dp_s    = 1'b0;
`endif

  // Character of the digit about to be shown.
  always_comb begin
    case (digit_s)
      2'd0:    lit_char_s = active_char_r[0];
      2'd1:    lit_char_s = active_char_r[1];
      2'd2:    lit_char_s = active_char_r[2];
      default: lit_char_s = CH_BLANK;
    endcase
  end

  seg_encode u_seg_encode (
    .ch  (lit_char_s),
    .seg (seg_s)
  );

  // Output values for the next state, registered alongside it.
  always_comb begin
    sel_s  = SEL_NONE;
    data_s = 8'h00;
    if (state_s == ST_LIT) begin
      sel_s  = digit_onehot(digit_s);
      data_s = {lit_dp_s, seg_s};
    end else begin
      sel_s  = SEL_NONE;
      data_s = 8'h00;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (DIV=4, BLANK=2): directed sequences,
// a glyph table and random traffic checked against a frame-position model.
module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = DIV + BLANK;
  localparam int FRAME = 3 * SLOT;
`ifdef SEG_SCAN_DP_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_idx = 2'd0;
  logic [4:0] wr_char = 5'h00;
  logic       wr_dp = 1'b0;
  logic       commit = 1'b0;
  logic [2:0] sel;
  logic [7:0] data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_idx   (wr_idx),
    .wr_char  (wr_char),
    .wr_dp    (wr_dp),
    .commit   (commit),
    .sel      (sel),
    .data     (data)
  );

  // Reference model: k = clock edges since reset release; frame position decides display.
  int         k;
  logic [4:0] m_sh [3];
  logic [4:0] m_act [3];
  logic       m_shdp [3];
  logic       m_actdp [3];
  bit         m_pend;
  bit         m_ready;

  function automatic logic [6:0] ref_seg(input logic [4:0] c);
    case (c)
      5'h00: return 7'h3F;  5'h01: return 7'h06;  5'h02: return 7'h5B;  5'h03: return 7'h4F;
      5'h04: return 7'h66;  5'h05: return 7'h6D;  5'h06: return 7'h7D;  5'h07: return 7'h07;
      5'h08: return 7'h7F;  5'h09: return 7'h6F;  5'h0A: return 7'h77;  5'h0B: return 7'h7C;
      5'h0C: return 7'h39;  5'h0D: return 7'h5E;  5'h0E: return 7'h79;  5'h0F: return 7'h71;
      5'h10: return 7'h6D;  5'h11: return 7'h79;  5'h12: return 7'h73;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [2:0] exp_sel();
    int n = k % FRAME;
    if ((n % SLOT) >= BLANK) return 3'(1 << (n / SLOT));
    return 3'b000;
  endfunction

  function automatic logic [7:0] exp_data();
    int n = k % FRAME;
    int s = n / SLOT;
    if ((n % SLOT) >= BLANK) return {(DP_EN ? m_actdp[s] : 1'b0), ref_seg(m_act[s])};
    return 8'h00;
  endfunction

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 3; i++) begin
      m_sh[i] = 5'h1F; m_act[i] = 5'h1F; m_shdp[i] = 1'b0; m_actdp[i] = 1'b0;
    end
    m_pend  = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic model_edge();
    bit fire, cfire, copy;
    k++;
    fire  = wr_valid && m_ready;
    cfire = commit && m_ready;
    copy  = ((k % FRAME) == 0) && m_pend;
    if (copy) begin
      for (int i = 0; i < 3; i++) begin m_act[i] = m_sh[i]; m_actdp[i] = m_shdp[i]; end
    end
    if (fire && (wr_idx != 2'd3)) begin
      m_sh[int'(wr_idx)]   = wr_char;
      m_shdp[int'(wr_idx)] = wr_dp;
    end
    if (copy)       m_pend = 1'b0;
    else if (cfire) m_pend = 1'b1;
    m_ready = !m_pend && !copy;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s k=%0d: got %02h expected %02h", name, k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_sel", {5'b0, sel}, {5'b0, exp_sel()});
    chk("model_data", data, exp_data());
    chk("model_ready", {7'b0, wr_ready}, {7'b0, m_ready});
  endtask

  task automatic wait_sel(input logic [2:0] s, input string name);
    int n = 0;
    while (sel !== s && n < 50) begin step(); n++; end
    chk(name, {5'b0, sel}, {5'b0, s});
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (wr_ready !== 1'b1 && n < 60) begin step(); n++; end
    chk(name, {7'b0, wr_ready}, 8'h01);
  endtask

  // Run to the next frame boundary, then capture one full frame per digit.
  task automatic check_frame(input string name, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2);
    logic [7:0] d [3];
    int n = 0;
    while ((k % FRAME) != 0 && n < 40) begin step(); n++; end
    chk({name, "_sync"}, 8'((k % FRAME)), 8'h00);
    for (int i = 0; i < 3; i++) d[i] = 8'hEE;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (sel === 3'b001) d[0] = data;
      if (sel === 3'b010) d[1] = data;
      if (sel === 3'b100) d[2] = data;
    end
    chk({name, "_d0"}, d[0], e0);
    chk({name, "_d1"}, d[1], e1);
    chk({name, "_d2"}, d[2], e2);
  endtask

  typedef struct {
    logic [4:0] ch;
    logic       dp;
    logic [7:0] exp;
  } vec_t;

  initial begin
    vec_t       vecs [$];
    logic [2:0] exp_seq [FRAME];
    int         kc, low, bnd;

    vecs.push_back('{5'h00, 1'b0, 8'h3F}); vecs.push_back('{5'h01, 1'b0, 8'h06});
    vecs.push_back('{5'h02, 1'b0, 8'h5B}); vecs.push_back('{5'h03, 1'b0, 8'h4F});
    vecs.push_back('{5'h04, 1'b0, 8'h66}); vecs.push_back('{5'h05, 1'b0, 8'h6D});
    vecs.push_back('{5'h06, 1'b0, 8'h7D}); vecs.push_back('{5'h07, 1'b0, 8'h07});
    vecs.push_back('{5'h08, 1'b0, 8'h7F}); vecs.push_back('{5'h09, 1'b0, 8'h6F});
    vecs.push_back('{5'h0A, 1'b0, 8'h77}); vecs.push_back('{5'h0B, 1'b0, 8'h7C});
    vecs.push_back('{5'h0C, 1'b0, 8'h39}); vecs.push_back('{5'h0D, 1'b0, 8'h5E});
    vecs.push_back('{5'h0E, 1'b0, 8'h79}); vecs.push_back('{5'h0F, 1'b0, 8'h71});
    vecs.push_back('{5'h10, 1'b0, 8'h6D}); vecs.push_back('{5'h11, 1'b0, 8'h79});
    vecs.push_back('{5'h12, 1'b0, 8'h73}); vecs.push_back('{5'h13, 1'b0, 8'h00});
    vecs.push_back('{5'h1F, 1'b0, 8'h00});
    vecs.push_back('{5'h08, 1'b1, (DP_EN ? 8'hFF : 8'h7F)});

    for (int s = 0; s < 3; s++)
      for (int r = 0; r < SLOT; r++)
        exp_seq[s * SLOT + r] = (r < BLANK) ? 3'b000 : 3'(1 << s);

    // Reset state, then one idle frame after release.
    model_reset();
    #12;
    chk("reset_sel", {5'b0, sel}, 8'h00);
    chk("reset_data", data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) step();
      chk("idle_sel", {5'b0, sel}, {5'b0, exp_seq[i]});
      chk("idle_data", data, 8'h00);
    end

    // S/E/P written mid-frame with commit alongside the last write.
    repeat (8) step();
    wr_valid = 1'b1; wr_idx = 2'd0; wr_char = 5'h10; step();
    wr_idx = 2'd1; wr_char = 5'h11; step();
    wr_idx = 2'd2; wr_char = 5'h12; commit = 1'b1; step();
    wr_valid = 1'b0; commit = 1'b0;
    check_frame("sep", 8'h6D, 8'h79, 8'h73);

    // Commit during digit 0: ready low until one cycle after the frame boundary.
    wait_ready("c0_ready");
    wait_sel(3'b001, "c0_sel");
    commit = 1'b1; step(); commit = 1'b0;
    kc  = k;
    bnd = ((kc / FRAME) + 1) * FRAME;
    low = 0;
    while (wr_ready === 1'b0 && low < 60) begin
      low++;
      wr_valid = 1'b1; wr_idx = 2'd0; wr_char = 5'h03;
      step();
    end
    wr_valid = 1'b0;
    chk("c0_low_cycles", 8'(low), 8'(bnd + 1 - kc));

    // Index-3 write with commit changes nothing; also exposes any leaked write above.
    wr_valid = 1'b1; wr_idx = 2'd3; wr_char = 5'h05; commit = 1'b1; step();
    wr_valid = 1'b0; commit = 1'b0;
    wait_ready("idx3_ready");
    check_frame("idx3", 8'h6D, 8'h79, 8'h73);

    // Reset pulse during digit 1 with a commit pending.
    commit = 1'b1; step(); commit = 1'b0;
    wait_sel(3'b010, "rst_sel_d1");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_sel", {5'b0, sel}, 8'h00);
    chk("rst_mid_data", data, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_ready", {7'b0, wr_ready}, 8'h01);
    check_frame("rst_blank", 8'h00, 8'h00, 8'h00);

    // Glyph table on digit 1.
    foreach (vecs[i]) begin
      wait_ready("tbl_ready");
      wr_valid = 1'b1; wr_idx = 2'd1; wr_char = vecs[i].ch; wr_dp = vecs[i].dp; commit = 1'b1;
      step();
      wr_valid = 1'b0; commit = 1'b0; wr_dp = 1'b0;
      step();
      wait_ready("tbl_ready2");
      wait_sel(3'b010, "tbl_sel");
      chk($sformatf("tbl_%02h_dp%0d", vecs[i].ch, vecs[i].dp), data, vecs[i].exp);
    end

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_idx   = 2'($urandom_range(0, 3));
      wr_char  = 5'($urandom_range(0, 31));
      wr_dp    = 1'($urandom_range(0, 1));
      commit   = ($urandom_range(0, 5) == 0);
      step();
    end
    wr_valid = 1'b0; commit = 1'b0;
    repeat (2 * FRAME) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
